// File: rtl/mag_min_find_3bit_seq.sv
// -----------------------------------------------------------------------------
// mag_min_find_3bit_seq
//   Streaming minimum-finder for the 3-bit reliability magnitudes of one BCH
//   codeword frame. A running minimum value and its beat index are kept per
//   frame. One result pulse is issued per frame, in the cycle after the eop
//   beat. Beats are compared with the carry-lookahead magnitude comparator
//   mag_comp_CLA_3bit_comb.
//
//   Optional feature macro: MIN_FIND_2ND_EN
//     defined   -> the second smallest magnitude and its index are also
//                  tracked, using a second comparator instance;
//                  ports out_min2 / out_min2_idx are present.
//     undefined -> one comparator only; those ports are absent.
//
// Ports
//   clk           clock, rising edge
//   rst_b         asynchronous active-low reset
//   in_vld        symbol beat valid
//   in_sop        first beat of frame (qualified by in_vld)
//   in_eop        last beat of frame (qualified by in_vld)
//   in_mag        reliability magnitude (0 = least reliable)
//   out_vld       one-cycle result pulse
//   out_min       smallest magnitude of the frame
//   out_min_idx   0-based beat index of out_min
//   out_min2      second smallest magnitude   (MIN_FIND_2ND_EN only)
//   out_min2_idx  index of out_min2           (MIN_FIND_2ND_EN only)
//   out_ovf       frame had more than FRAME_LEN beats; valid with out_vld
//   out_abort     one-cycle pulse: frame dropped because of an early in_sop
//   out_busy      high while a frame is being accumulated
//
// State table
//   S_IDLE | waiting for an in_sop beat
//   S_ACC  | accumulating beats of the current frame
//   S_DONE | result cycle: out_vld high; a new sop may be accepted here
// -----------------------------------------------------------------------------

// 3-bit magnitude comparator; out_cp = 1 when in_a > in_b.
// a >= b is the carry out of a + ~b + 1, built with lookahead terms.
module mag_comp_CLA_3bit_comb (
    input  logic [2:0] in_a,
    input  logic [2:0] in_b,
    output logic       out_cp
);
    logic [2:0] g;
    logic [2:0] p;
    logic       c3;
    logic       eq;

    assign g  = in_a & ~in_b;
    assign p  = in_a | ~in_b;
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0]);
    assign eq = &(in_a ~^ in_b);
    assign out_cp = c3 & ~eq;
endmodule

module mag_min_find_3bit_seq #(
    parameter int IDX_W     = 9,
    parameter int FRAME_LEN = 511
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             in_vld,
    input  logic             in_sop,
    input  logic             in_eop,
    input  logic [2:0]       in_mag,
    output logic             out_vld,
    output logic [2:0]       out_min,
    output logic [IDX_W-1:0] out_min_idx,
`ifdef MIN_FIND_2ND_EN
    output logic [2:0]       out_min2,
    output logic [IDX_W-1:0] out_min2_idx,
`endif
    output logic             out_ovf,
    output logic             out_abort,
    output logic             out_busy
);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

    localparam logic [IDX_W:0] FRAME_LEN_C = (IDX_W+1)'(FRAME_LEN);

    state_t           state_q, state_d;

    logic [2:0]       min_q,  min_d;
    logic [IDX_W-1:0] idx_q,  idx_d;
    logic [IDX_W-1:0] cnt_q,  cnt_d;
    logic             ovf_q,  ovf_d;
    logic             abort_q;
    logic [2:0]       res_min_q;
    logic [IDX_W-1:0] res_idx_q;
    logic             res_ovf_q;

    logic             load;
    logic             accum;
    logic             lt_min;

    // A sop beat always (re)starts a frame, whatever the state.
    assign load  = in_vld & in_sop;
    assign accum = in_vld & ~in_sop & (state_q == S_ACC);

    mag_comp_CLA_3bit_comb u_cmp_min (
        .in_a   (min_q),
        .in_b   (in_mag),
        .out_cp (lt_min)
    );

`ifdef MIN_FIND_2ND_EN
    logic [2:0]       min2_q, min2_d;
    logic [IDX_W-1:0] idx2_q, idx2_d;
    logic [2:0]       res_min2_q;
    logic [IDX_W-1:0] res_idx2_q;
    logic             lt_min2;

    mag_comp_CLA_3bit_comb u_cmp_min2 (
        .in_a   (min2_q),
        .in_b   (in_mag),
        .out_cp (lt_min2)
    );
`endif

    // State register
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (load) state_d = in_eop ? S_DONE : S_ACC;
            S_ACC:   if (in_vld && in_eop) state_d = S_DONE;
            S_DONE:  if (load) state_d = in_eop ? S_DONE : S_ACC;
                     else      state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        out_vld  = (state_q == S_DONE);
        out_busy = (state_q == S_ACC);
    end

    // Running accumulator next values; the eop beat's values go straight
    // into the result registers so results appear together with out_vld.
    always_comb begin
        min_d = min_q;
        idx_d = idx_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
`ifdef MIN_FIND_2ND_EN
        min2_d = min2_q;
        idx2_d = idx2_q;
`endif
        if (load) begin
            min_d = in_mag;
            idx_d = '0;
            cnt_d = IDX_W'(1);
            ovf_d = 1'b0;
`ifdef MIN_FIND_2ND_EN
            min2_d = 3'd7;
            idx2_d = '1;
`endif
        end else if (accum) begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + IDX_W'(1);
            if ({1'b0, cnt_q} >= FRAME_LEN_C) ovf_d = 1'b1;
            if (lt_min) begin
                min_d = in_mag;
                idx_d = cnt_q;
`ifdef MIN_FIND_2ND_EN
                min2_d = min_q;
                idx2_d = idx_q;
            end else if (lt_min2) begin
                min2_d = in_mag;
                idx2_d = cnt_q;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            min_q     <= 3'd7;
            idx_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            abort_q   <= 1'b0;
            res_min_q <= '0;
            res_idx_q <= '0;
            res_ovf_q <= 1'b0;
        end else begin
            min_q   <= min_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            abort_q <= load & (state_q == S_ACC);
            if ((load | accum) & in_eop) begin
                res_min_q <= min_d;
                res_idx_q <= idx_d;
                res_ovf_q <= ovf_d;
            end
        end
    end

`ifdef MIN_FIND_2ND_EN
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            min2_q     <= 3'd7;
            idx2_q     <= '1;
            res_min2_q <= '0;
            res_idx2_q <= '0;
        end else begin
            min2_q <= min2_d;
            idx2_q <= idx2_d;
            if ((load | accum) & in_eop) begin
                res_min2_q <= min2_d;
                res_idx2_q <= idx2_d;
            end
        end
    end

    assign out_min2     = res_min2_q;
    assign out_min2_idx = res_idx2_q;
`endif

    assign out_min     = res_min_q;
    assign out_min_idx = res_idx_q;
    assign out_ovf     = res_ovf_q;
    assign out_abort   = abort_q;

endmodule

// File: tb/tb_mag_min_find_3bit_seq.sv
module tb_mag_min_find_3bit_seq;

    logic       clk = 1'b0;
    logic       rst_b = 1'b0;
    logic       in_vld = 1'b0;
    logic       in_sop = 1'b0;
    logic       in_eop = 1'b0;
    logic [2:0] in_mag = 3'd0;
    logic       out_vld;
    logic [2:0] out_min;
    logic [8:0] out_min_idx;
`ifdef MIN_FIND_2ND_EN
    logic [2:0] out_min2;
    logic [8:0] out_min2_idx;
`endif
    logic       out_ovf;
    logic       out_abort;
    logic       out_busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mag_min_find_3bit_seq #(.IDX_W(9), .FRAME_LEN(511)) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .in_vld       (in_vld),
        .in_sop       (in_sop),
        .in_eop       (in_eop),
        .in_mag       (in_mag),
        .out_vld      (out_vld),
        .out_min      (out_min),
        .out_min_idx  (out_min_idx),
`ifdef MIN_FIND_2ND_EN
        .out_min2     (out_min2),
        .out_min2_idx (out_min2_idx),
`endif
        .out_ovf      (out_ovf),
        .out_abort    (out_abort),
        .out_busy     (out_busy)
    );

    typedef struct {
        int              n;
        logic [0:7][2:0] mags;
        logic [2:0]      e_min;
        logic [8:0]      e_idx;
        logic [2:0]      e_min2;
        logic [8:0]      e_idx2;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs; returns 1 time unit after the sampling edge.
    task automatic beat(input logic v, input logic s, input logic e, input logic [2:0] m);
        in_vld = v;
        in_sop = s;
        in_eop = e;
        in_mag = m;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_result(input string name, input logic [2:0] e_min, input logic [8:0] e_idx,
                              input logic [2:0] e_min2, input logic [8:0] e_idx2, input logic e_ovf);
        chk({name, ".vld"}, 32'(out_vld), 32'd1);
        chk({name, ".min"}, 32'(out_min), 32'(e_min));
        chk({name, ".idx"}, 32'(out_min_idx), 32'(e_idx));
        chk({name, ".ovf"}, 32'(out_ovf), 32'(e_ovf));
`ifdef MIN_FIND_2ND_EN
        chk({name, ".min2"}, 32'(out_min2), 32'(e_min2));
        chk({name, ".idx2"}, 32'(out_min2_idx), 32'(e_idx2));
`else
        if (e_min2 == 3'd0 && e_idx2 == 9'd0) chk({name, ".min2_unused"}, 32'(out_busy), 32'd0);
`endif
    endtask

    initial begin
        vecs[0] = '{5, {3'd5, 3'd3, 3'd6, 3'd1, 3'd4, 3'd0, 3'd0, 3'd0}, 3'd1, 9'd3, 3'd3, 9'd1};
        vecs[1] = '{4, {3'd2, 3'd2, 3'd7, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0}, 3'd2, 9'd0, 3'd2, 9'd1};
        vecs[2] = '{1, {3'd6, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}, 3'd6, 9'd0, 3'd7, 9'h1FF};
        vecs[3] = '{3, {3'd7, 3'd7, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}, 3'd7, 9'd0, 3'd7, 9'h1FF};
        vecs[4] = '{4, {3'd0, 3'd4, 3'd0, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0}, 3'd0, 9'd0, 3'd0, 9'd2};
        vecs[5] = '{5, {3'd4, 3'd6, 3'd5, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0}, 3'd1, 9'd4, 3'd2, 9'd3};

        // Reset state
        @(posedge clk);
        #1;
        chk("rst.vld", 32'(out_vld), 32'd0);
        chk("rst.min", 32'(out_min), 32'd0);
        chk("rst.idx", 32'(out_min_idx), 32'd0);
        chk("rst.ovf", 32'(out_ovf), 32'd0);
        chk("rst.abort", 32'(out_abort), 32'd0);
        chk("rst.busy", 32'(out_busy), 32'd0);
        rst_b = 1'b1;
        beat(0, 0, 0, 3'd0);

        // Reset in the middle of a frame
        beat(1, 1, 0, 3'd3);
        for (int i = 0; i < 4; i++) beat(1, 0, 0, 3'd1);
        chk("midrst.busy_before", 32'(out_busy), 32'd1);
        rst_b = 1'b0;
        in_vld = 1'b0;
        in_sop = 1'b0;
        in_mag = 3'd0;
        #1;
        chk("midrst.busy", 32'(out_busy), 32'd0);
        chk("midrst.vld", 32'(out_vld), 32'd0);
        chk("midrst.min", 32'(out_min), 32'd0);
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        beat(0, 0, 0, 3'd0);
        chk("midrst.vld_after", 32'(out_vld), 32'd0);
        chk("midrst.abort_after", 32'(out_abort), 32'd0);

        // A valid beat without sop in IDLE is ignored
        beat(1, 0, 1, 3'd0);
        chk("nosop.busy", 32'(out_busy), 32'd0);
        chk("nosop.vld", 32'(out_vld), 32'd0);
        beat(0, 0, 0, 3'd0);
        chk("nosop.vld2", 32'(out_vld), 32'd0);

        // Table-driven frames
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < vecs[k].n; i++)
                beat(1, i == 0, i == vecs[k].n - 1, vecs[k].mags[i]);
            chk_result($sformatf("vec%0d", k), vecs[k].e_min, vecs[k].e_idx,
                       vecs[k].e_min2, vecs[k].e_idx2, 1'b0);
            beat(0, 0, 0, 3'd0);
            chk($sformatf("vec%0d.pulse", k), 32'(out_vld), 32'd0);
            chk($sformatf("vec%0d.hold", k), 32'(out_min), 32'(vecs[k].e_min));
        end

        // Gaps inside a frame; in_mag with in_vld low must be ignored
        beat(1, 1, 0, 3'd5);
        beat(0, 0, 0, 3'd0);
        beat(1, 0, 0, 3'd2);
        beat(0, 0, 1, 3'd0);
        chk("gap.busy", 32'(out_busy), 32'd1);
        beat(1, 0, 1, 3'd3);
        chk_result("gap", 3'd2, 9'd1, 3'd3, 9'd2, 1'b0);
        beat(0, 0, 0, 3'd0);

        // Early sop aborts frame A; frame B restarts at index 0
        beat(1, 1, 0, 3'd3);
        beat(1, 0, 0, 3'd1);
        beat(1, 0, 0, 3'd2);
        chk("abort.pre", 32'(out_abort), 32'd0);
        beat(1, 1, 0, 3'd4);
        chk("abort.pulse", 32'(out_abort), 32'd1);
        chk("abort.busy", 32'(out_busy), 32'd1);
        chk("abort.novld", 32'(out_vld), 32'd0);
        beat(1, 0, 0, 3'd5);
        chk("abort.pulse_end", 32'(out_abort), 32'd0);
        beat(1, 0, 0, 3'd0);
        beat(1, 0, 1, 3'd6);
        chk_result("abort.B", 3'd0, 9'd2, 3'd4, 9'd0, 1'b0);
        beat(0, 0, 0, 3'd0);

        // 511 beats: exactly FRAME_LEN, no overflow
        for (int i = 0; i < 511; i++) beat(1, i == 0, i == 510, (i == 510) ? 3'd4 : 3'd7);
        chk_result("len511", 3'd4, 9'd510, 3'd7, 9'd0, 1'b0);
        beat(0, 0, 0, 3'd0);

        // 512 beats: overflow, then frame B starts in the DONE cycle
        for (int i = 0; i < 512; i++)
            beat(1, i == 0, i == 511, (i == 0) ? 3'd6 : (i == 100) ? 3'd3 : (i == 511) ? 3'd1 : 3'd7);
        chk_result("len512", 3'd1, 9'd511, 3'd3, 9'd100, 1'b1);
        beat(1, 1, 0, 3'd2);
        chk("b2b.gap_vld", 32'(out_vld), 32'd0);
        chk("b2b.hold_min", 32'(out_min), 32'd1);
        chk("b2b.hold_ovf", 32'(out_ovf), 32'd1);
        chk("b2b.no_abort", 32'(out_abort), 32'd0);
        beat(1, 0, 1, 3'd5);
        chk_result("b2b.B", 3'd2, 9'd0, 3'd5, 9'd1, 1'b0);
        beat(0, 0, 0, 3'd0);

        // 514 beats: index saturates at 511
        for (int i = 0; i < 514; i++)
            beat(1, i == 0, i == 513, (i == 0) ? 3'd5 : (i == 513) ? 3'd0 : 3'd7);
        chk_result("sat", 3'd0, 9'd511, 3'd5, 9'd0, 1'b1);
        beat(0, 0, 0, 3'd0);

        // Single-beat frames back to back, each restarting in DONE
        beat(1, 1, 1, 3'd3);
        chk_result("single1", 3'd3, 9'd0, 3'd7, 9'h1FF, 1'b0);
        beat(1, 1, 1, 3'd1);
        chk_result("single2", 3'd1, 9'd0, 3'd7, 9'h1FF, 1'b0);
        beat(0, 0, 0, 3'd0);
        chk("single.end", 32'(out_vld), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
